// File: rtl/piso_shift_reg_pkg.sv
// Shared shift-register definitions: FSM state encoding and default word width.
package piso_shift_reg_pkg;

    localparam int unsigned SR_DEFAULT_WIDTH = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } sr_state_e;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in/serial-out shift register with valid/ready load and framing strobes.
// Back-to-back words are accepted on the last-bit cycle for gap-free streaming.
module piso_shift_reg
    import piso_shift_reg_pkg::*;
#(
    parameter int unsigned WIDTH     = SR_DEFAULT_WIDTH,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] p_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             shift_en,
    output logic             s_out,
    output logic             s_valid,
    output logic             s_last,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    sr_state_e        state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             s_out_q, s_out_d;
    logic             s_valid_q, s_valid_d;
    logic             s_last_q, s_last_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] shifted;
    logic             last_bit;

    assign last_bit = (cnt_q == '0);

    // Ready while idle, or on the final enabled bit so a new word follows with no gap.
    assign load_ready = rst && ((state_q == IDLE) ||
                                (state_q == SHIFT && last_bit && shift_en));

    always_comb begin
        if (MSB_FIRST) begin
            shifted = {shreg_q[WIDTH-2:0], 1'b0};
        end else begin
            shifted = {1'b0, shreg_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            IDLE: begin
                if (load_valid) begin
                    shreg_d = p_in;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_en) begin
                    if (!last_bit) begin
                        shreg_d = shifted;
                        cnt_d   = cnt_q - CNT_W'(1);
                    end else if (load_valid) begin
                        shreg_d = p_in;
                        cnt_d   = CNT_W'(WIDTH - 1);
                    end else begin
                        shreg_d = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        s_valid_d = (state_d == SHIFT);
        busy_d    = (state_d == SHIFT);
        s_last_d  = (state_d == SHIFT) && (cnt_d == '0);
        if (state_d == SHIFT) begin
            s_out_d = MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0];
        end else begin
            s_out_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            cnt_q     <= '0;
            s_out_q   <= 1'b0;
            s_valid_q <= 1'b0;
            s_last_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            s_out_q   <= s_out_d;
            s_valid_q <= s_valid_d;
            s_last_q  <= s_last_d;
            busy_q    <= busy_d;
        end
    end

    assign s_out   = s_out_q;
    assign s_valid = s_valid_q;
    assign s_last  = s_last_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_piso_shift_reg.sv
// Bench for piso_shift_reg: MSB-first and LSB-first instances against a word/bit-index model.
module tb_piso_shift_reg;

    localparam int unsigned W = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] p_in;
    logic         load_valid;
    logic         shift_en;

    logic m_load_ready, m_s_out, m_s_valid, m_s_last, m_busy;
    logic l_load_ready, l_s_out, l_s_valid, l_s_last, l_busy;

    int n_checks;
    int n_fail;

    // Reference model: the word in flight and the index of the bit being presented.
    logic [W-1:0] mdl_word;
    int           mdl_pos;
    bit           mdl_active;

    piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk        (clk),
        .rst        (rst),
        .p_in       (p_in),
        .load_valid (load_valid),
        .load_ready (m_load_ready),
        .shift_en   (shift_en),
        .s_out      (m_s_out),
        .s_valid    (m_s_valid),
        .s_last     (m_s_last),
        .busy       (m_busy)
    );

    piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk        (clk),
        .rst        (rst),
        .p_in       (p_in),
        .load_valid (load_valid),
        .load_ready (l_load_ready),
        .shift_en   (shift_en),
        .s_out      (l_s_out),
        .s_valid    (l_s_valid),
        .s_last     (l_s_last),
        .busy       (l_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input bit msb_first);
        if (!mdl_active) return 1'b0;
        return msb_first ? mdl_word[W-1-mdl_pos] : mdl_word[mdl_pos];
    endfunction

    // One clock: drive inputs, check load_ready, clock, advance model, check outputs.
    task automatic step(input logic r, input logic lv, input logic [W-1:0] d, input logic se);
        logic exp_rdy;
        rst        = r;
        load_valid = lv;
        p_in       = d;
        shift_en   = se;
        #1;
        exp_rdy = r && (!mdl_active || (mdl_pos == W - 1 && se));
        check_eq("load_ready_msb", 32'(m_load_ready), 32'(exp_rdy));
        check_eq("load_ready_lsb", 32'(l_load_ready), 32'(exp_rdy));
        @(posedge clk);
        if (!r) begin
            mdl_active = 1'b0;
            mdl_pos    = 0;
        end else if (!mdl_active) begin
            if (lv) begin
                mdl_word   = d;
                mdl_pos    = 0;
                mdl_active = 1'b1;
            end
        end else if (se) begin
            if (mdl_pos == W - 1) begin
                if (lv) begin
                    mdl_word = d;
                    mdl_pos  = 0;
                end else begin
                    mdl_active = 1'b0;
                    mdl_pos    = 0;
                end
            end else begin
                mdl_pos++;
            end
        end
        #1;
        check_eq("s_out_msb",   32'(m_s_out),   32'(exp_bit(1'b1)));
        check_eq("s_out_lsb",   32'(l_s_out),   32'(exp_bit(1'b0)));
        check_eq("s_valid_msb", 32'(m_s_valid), 32'(mdl_active));
        check_eq("s_valid_lsb", 32'(l_s_valid), 32'(mdl_active));
        check_eq("busy_msb",    32'(m_busy),    32'(mdl_active));
        check_eq("busy_lsb",    32'(l_busy),    32'(mdl_active));
        check_eq("s_last_msb",  32'(m_s_last),  32'(mdl_active && mdl_pos == W - 1));
        check_eq("s_last_lsb",  32'(l_s_last),  32'(mdl_active && mdl_pos == W - 1));
    endtask

    initial begin
        logic [W-1:0] seq;
        int           last_cnt;
        int           valid_cnt;
        logic [7:0]   stream;

        n_checks   = 0;
        n_fail     = 0;
        mdl_word   = '0;
        mdl_pos    = 0;
        mdl_active = 1'b0;
        rst        = 1'b0;
        load_valid = 1'b0;
        p_in       = '0;
        shift_en   = 1'b0;

        // Reset with a pending load that must be ignored.
        step(1'b0, 1'b1, 4'b1111, 1'b1);
        step(1'b0, 1'b1, 4'b1111, 1'b1);
        check_eq("rst_s_valid", 32'(m_s_valid), 32'd0);
        check_eq("rst_s_out",   32'(m_s_out),   32'd0);
        rst        = 1'b1;
        load_valid = 1'b0;
        #1;
        check_eq("rst_release_ready", 32'(m_load_ready), 32'd1);

        // Basic MSB-first 1001; LSB-first instance sees the same pattern.
        seq = 4'b1001;
        step(1'b1, 1'b1, 4'b1001, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check_eq("basic_msb_bit", 32'(m_s_out), 32'(seq[3-k]));
            check_eq("basic_last", 32'(m_s_last), 32'(k == 3));
            if (k < 3) step(1'b1, 1'b0, 4'b0000, 1'b1);
        end
        step(1'b1, 1'b0, 4'b0000, 1'b1);
        check_eq("basic_end_valid", 32'(m_s_valid), 32'd0);
        check_eq("basic_end_busy",  32'(m_busy),    32'd0);

        // LSB-first 1101 serialises as 1,0,1,1.
        seq = 4'b1101;
        step(1'b1, 1'b1, 4'b1101, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check_eq("lsb_bit", 32'(l_s_out), 32'(seq[k]));
            step(1'b1, 1'b0, 4'b0000, 1'b1);
        end

        // Stall after bit 1 of 1010.
        last_cnt = 0;
        step(1'b1, 1'b1, 4'b1010, 1'b1);
        check_eq("stall_b0", 32'(m_s_out), 32'd1);
        step(1'b1, 1'b0, 4'b0000, 1'b1);
        check_eq("stall_b1", 32'(m_s_out), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b0, 4'b0000, 1'b0);
            check_eq("stall_hold", 32'(m_s_out), 32'd0);
            last_cnt += int'(m_s_last);
        end
        step(1'b1, 1'b0, 4'b0000, 1'b1);
        check_eq("stall_b2", 32'(m_s_out), 32'd1);
        last_cnt += int'(m_s_last);
        step(1'b1, 1'b0, 4'b0000, 1'b1);
        check_eq("stall_b3", 32'(m_s_out), 32'd0);
        last_cnt += int'(m_s_last);
        check_eq("stall_last_once", 32'(last_cnt), 32'd1);
        step(1'b1, 1'b0, 4'b0000, 1'b1);

        // Back-to-back 1100 then 0011.
        valid_cnt = 0;
        stream    = '0;
        step(1'b1, 1'b1, 4'b1100, 1'b1);
        for (int k = 0; k < 8; k++) begin
            valid_cnt += int'(m_s_valid);
            stream = {stream[6:0], m_s_out};
            check_eq("b2b_last", 32'(m_s_last), 32'(k == 3 || k == 7));
            if (k == 3) begin
                load_valid = 1'b1;
                p_in       = 4'b0011;
                #1;
                check_eq("b2b_ready_pulse", 32'(m_load_ready), 32'd1);
            end
            if (k < 7) step(1'b1, (k < 4), 4'b0011, 1'b1);
        end
        check_eq("b2b_valid_cnt", 32'(valid_cnt), 32'd8);
        check_eq("b2b_stream", 32'(stream), 32'h0000_00C3);
        step(1'b1, 1'b0, 4'b0000, 1'b1);

        // Mid-word reset after bit 2, then a fresh word.
        step(1'b1, 1'b1, 4'b1111, 1'b1);
        step(1'b1, 1'b0, 4'b0000, 1'b1);
        step(1'b1, 1'b0, 4'b0000, 1'b1);
        step(1'b0, 1'b0, 4'b0000, 1'b1);
        check_eq("midrst_valid", 32'(m_s_valid), 32'd0);
        check_eq("midrst_out",   32'(m_s_out),   32'd0);
        seq = 4'b0101;
        step(1'b1, 1'b1, 4'b0101, 1'b1);
        for (int k = 0; k < 4; k++) begin
            check_eq("midrst_fresh_bit", 32'(m_s_out), 32'(seq[3-k]));
            step(1'b1, 1'b0, 4'b0000, 1'b1);
        end

        // Randomised traffic with occasional resets and stalls.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 1) == 1),
                 W'($urandom),
                 ($urandom_range(0, 3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
